// File: rtl/fifo_write_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port between NUM_REQ requesters.
// Latency: one-cycle arbitration bubble, then 1 beat/cycle; fifo_full or granted-valid-low stalls the burst in place.
module fifo_write_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDW-1:0]        r_rr_ptr;
  logic [IDW-1:0]        w_rr_ptr_nxt;
  logic [IDW-1:0]        r_grant_id;
  logic [IDW-1:0]        w_grant_id_nxt;
  logic [IDW-1:0]        w_scan_id;
  logic [IDW-1:0]        w_next_id;
  logic [BCW-1:0]        r_beat_cnt;
  logic [BCW-1:0]        w_beat_cnt_nxt;
  logic                  w_scan_hit;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_slot [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign w_slot[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int w_idx;
    w_idx      = 0;
    w_scan_hit = 1'b0;
    w_scan_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_scan_hit && req_valid[w_idx]) begin
        w_scan_hit = 1'b1;
        w_scan_id  = IDW'(w_idx);
      end
    end
  end

  assign w_next_id = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_grant_id_nxt = r_grant_id;
    w_beat_cnt_nxt = r_beat_cnt;
    req_ready      = '0;
    fifo_w_en      = 1'b0;
    fifo_data_in   = '0;
    grant_valid    = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_scan_hit) begin
          w_grant_id_nxt = w_scan_id;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = S_GRANT;
        end
      end
      S_GRANT: begin
        grant_valid           = 1'b1;
        req_ready[r_grant_id] = !fifo_full;
        w_accept              = req_valid[r_grant_id] && !fifo_full;
        fifo_w_en             = w_accept;
        if (w_accept) begin
          fifo_data_in   = w_slot[r_grant_id];
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          if (req_last[r_grant_id] || (r_beat_cnt == BCW'(MAX_BURST - 1))) begin
            w_state_nxt    = S_IDLE;
            w_rr_ptr_nxt   = w_next_id;
            w_beat_cnt_nxt = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_fifo_write_rr_arbiter.sv
// Bench for fifo_write_rr_arbiter: directed scenarios plus random bursts, each cycle
// compared against a requester-queue / grant-order reference model.
module tb_fifo_write_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic          fifo_full, fifo_w_en, grant_valid;
  logic [DW-1:0] fifo_data_in;
  logic [1:0]    grant_id;

  always #5 clk = ~clk;

  fifo_write_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_w_en(fifo_w_en), .fifo_data_in(fifo_data_in),
    .grant_valid(grant_valid), .grant_id(grant_id));

  int vec = 0;
  int miss = 0;

  // Requester-side beat queues (each requester holds its head beat until accepted)
  logic [7:0] qd [N][512];
  bit         ql [N][512];
  int head [N], tail [N], hold [N];

  // Reference model: who holds the port, beats taken in this burst, next scan start
  bit m_grant;
  int m_gid, m_cnt, m_ptr, cyc;
  int         glog [$];
  logic [7:0] wlog [$];
  int         wcyc [$];
  int         wreq [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit last);
    qd[r][tail[r]] = d;
    ql[r][tail[r]] = last;
    tail[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = (head[i] < tail[i]) && (hold[i] == 0);
      req_data[i*DW +: DW]   = (head[i] < tail[i]) ? qd[i][head[i]] : 8'h00;
      req_last[i]            = (head[i] < tail[i]) ? ql[i][head[i]] : 1'b0;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] e_rdy;
    logic [7:0]   e_dat;
    bit           acc, found;
    int           idx;
    drive();
    @(negedge clk);
    e_rdy = '0;
    if (m_grant && !fifo_full) e_rdy[m_gid] = 1'b1;
    acc   = e_rdy[m_gid] && req_valid[m_gid];
    e_dat = acc ? qd[m_gid][head[m_gid]] : 8'h00;
    chk("grant_valid",  32'(grant_valid),  32'(m_grant));
    chk("grant_id",     32'(grant_id),     32'(m_gid));
    chk("req_ready",    32'(req_ready),    32'(e_rdy));
    chk("fifo_w_en",    32'(fifo_w_en),    32'(acc));
    chk("fifo_data_in", 32'(fifo_data_in), 32'(e_dat));
    @(posedge clk);
    if (!m_grant) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && req_valid[idx]) begin
          found = 1'b1; m_grant = 1'b1; m_gid = idx; m_cnt = 0;
          glog.push_back(idx);
        end
      end
    end else if (acc) begin
      wlog.push_back(e_dat);
      wcyc.push_back(cyc);
      wreq[m_gid]++;
      if (ql[m_gid][head[m_gid]] || m_cnt == MB - 1) begin
        m_grant = 1'b0; m_ptr = (m_gid + 1) % N; m_cnt = 0;
      end else begin
        m_cnt++;
      end
      head[m_gid]++;
    end
    for (int i = 0; i < N; i++) if (hold[i] > 0) hold[i]--;
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Requesters are reset along with the arbiter; outputs must drop at once.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; hold[i] = 0; wreq[i] = 0;
    end
    drive();
    #1;
    chk("rst_grant_valid", 32'(grant_valid),  32'd0);
    chk("rst_req_ready",   32'(req_ready),    32'd0);
    chk("rst_fifo_w_en",   32'(fifo_w_en),    32'd0);
    chk("rst_fifo_data",   32'(fifo_data_in), 32'd0);
    chk("rst_grant_id",    32'(grant_id),     32'd0);
    m_grant = 1'b0; m_gid = 0; m_cnt = 0; m_ptr = 0;
    glog.delete(); wlog.delete(); wcyc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, pending, blen, budget;
    int exp2 [5];
    int exp3 [5];
    exp2 = '{0, 1, 2, 3, 0};
    exp3 = '{1, 2, 3, 1, 1};
    fifo_full = 1'b0;
    cyc = 0;

    // 1: single 3-beat burst
    do_reset();
    push(0, 8'hA1, 0); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
    c0 = cyc;
    run(6);
    chk("t1_grants", 32'(glog.size()), 32'd1);
    chk("t1_gid", 32'(glog[0]), 32'd0);
    chk("t1_beats", 32'(wlog.size()), 32'd3);
    chk("t1_d0", 32'(wlog[0]), 32'hA1);
    chk("t1_d1", 32'(wlog[1]), 32'hA2);
    chk("t1_d2", 32'(wlog[2]), 32'hA3);
    chk("t1_first_lat", 32'(wcyc[0] - c0), 32'd1);
    chk("t1_back2back", 32'(wcyc[2] - wcyc[0]), 32'd2);

    // 2: all requesters, single-beat bursts
    do_reset();
    push(0, 8'h20, 1); push(0, 8'h21, 1);
    push(1, 8'h30, 1); push(2, 8'h40, 1); push(3, 8'h50, 1);
    run(14);
    chk("t2_grants", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("t2_order", 32'(glog[i]), 32'(exp2[i]));

    // 3: requester 1 streams without last; burst capped, others interleaved
    do_reset();
    for (int b = 0; b < 10; b++) push(1, 8'(8'h60 + b), 0);
    push(2, 8'h70, 1); push(3, 8'h80, 1);
    run(30);
    chk("t3_grants", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("t3_order", 32'(glog[i]), 32'(exp3[i]));
    chk("t3_req1_beats", 32'(wreq[1]), 32'd10);
    chk("t3_after_cap", 32'(wlog[4]), 32'h70);
    chk("t3_resume", 32'(wlog[6]), 32'h64);
    chk("t3_held", 32'(grant_valid), 32'd1);

    // 4: fifo_full for 3 cycles mid-burst; burst length must still be MAX_BURST
    do_reset();
    for (int b = 0; b < 5; b++) push(0, 8'(8'h10 + b), 0);
    run(3);
    fifo_full = 1'b1;
    run(3);
    fifo_full = 1'b0;
    run(6);
    chk("t4_beats", 32'(wlog.size()), 32'd5);
    chk("t4_d2", 32'(wlog[2]), 32'h12);
    chk("t4_stall_gap", 32'(wcyc[2] - wcyc[1]), 32'd4);
    chk("t4_grants", 32'(glog.size()), 32'd2);
    chk("t4_rearb_gap", 32'(wcyc[4] - wcyc[3]), 32'd2);

    // 5: granted requester drops valid for 2 cycles while requester 2 waits
    do_reset();
    push(0, 8'h90, 0); push(0, 8'h91, 0); push(0, 8'h92, 0); push(0, 8'h93, 1);
    push(2, 8'hB0, 1);
    run(3);
    hold[0] = 2;
    run(8);
    chk("t5_grants", 32'(glog.size()), 32'd2);
    chk("t5_g0", 32'(glog[0]), 32'd0);
    chk("t5_g1", 32'(glog[1]), 32'd2);
    chk("t5_gap", 32'(wcyc[2] - wcyc[1]), 32'd3);
    chk("t5_r2", 32'(wlog[4]), 32'hB0);

    // 6: reset mid-burst restarts round-robin at 0
    do_reset();
    push(2, 8'hC0, 1);
    run(3);
    push(0, 8'hD0, 0); push(0, 8'hD1, 0); push(0, 8'hD2, 0); push(0, 8'hD3, 1);
    run(3);
    chk("t6_pre_gid", 32'(glog[1]), 32'd0);
    chk("t6_pre_beats", 32'(wreq[0]), 32'd2);
    do_reset();
    push(1, 8'hE0, 1); push(3, 8'hE1, 1);
    run(6);
    chk("t6_first", 32'(glog[0]), 32'd1);
    chk("t6_second", 32'(glog[1]), 32'd3);

    // Random bursts with random full and valid gaps
    do_reset();
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0 && tail[i] < 490) begin
          blen = $urandom_range(1, 6);
          for (int b = 0; b < blen; b++) push(i, 8'($urandom), b == blen - 1);
        end
        if (hold[i] == 0 && $urandom_range(0, 15) == 0) hold[i] = $urandom_range(1, 3);
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      cycle();
    end
    fifo_full = 1'b0;
    budget = 0;
    pending = 1;
    while (pending != 0 && budget < 600) begin
      cycle();
      budget++;
      pending = 0;
      for (int i = 0; i < N; i++) pending += tail[i] - head[i];
    end
    chk("rand_drain", 32'(pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
